// File: rtl/vc_circular_buffer_if.sv
// Request/status bundle between the link receiver, the VC allocator and
// the multi-VC input buffer.
interface vc_circular_buffer_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int NUM_VC = 2
);
    localparam int VC_W  = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    // Requests are single-cycle strobes with no ready: an op takes effect at
    // the rising edge where its *_en is high and it is accepted; a rejected op
    // leaves state untouched and raises err_overflow/err_underflow next cycle.
    logic                    wr_en;
    logic [VC_W-1:0]         wr_vc;
    logic [DATA_W-1:0]       wr_data;
    logic                    rd_en;
    logic [VC_W-1:0]         rd_vc;
    logic [DATA_W-1:0]       rd_data;
    logic                    rd_valid;
    logic [NUM_VC-1:0]       empty;
    logic [NUM_VC-1:0]       full;
    logic [NUM_VC*CNT_W-1:0] count;
    logic [NUM_VC-1:0]       on_off;
    logic                    err_overflow;
    logic                    err_underflow;

    modport master (
        output wr_en, wr_vc, wr_data, rd_en, rd_vc,
        input  rd_data, rd_valid, empty, full, count, on_off,
               err_overflow, err_underflow
    );

    modport slave (
        input  wr_en, wr_vc, wr_data, rd_en, rd_vc,
        output rd_data, rd_valid, empty, full, count, on_off,
               err_overflow, err_underflow
    );
endinterface

// File: rtl/vc_circular_buffer.sv
// NUM_VC independent circular FIFOs sharing one storage array, with per-VC
// occupancy, full/empty, hysteretic on/off credit and error pulses.
module vc_circular_buffer #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int NUM_VC = 2,
    parameter int ON_TH  = 1,
    parameter int OFF_TH = 6
) (
    input  logic               clk,
    input  logic               rst,
    vc_circular_buffer_if.slave bus
);
    localparam int VC_W  = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ON_C     = CNT_W'(ON_TH);
    localparam logic [CNT_W-1:0] OFF_C    = CNT_W'(OFF_TH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic [DATA_W-1:0] mem [NUM_VC][DEPTH];
    logic [PTR_W-1:0]  wr_ptr [NUM_VC];
    logic [PTR_W-1:0]  rd_ptr [NUM_VC];
    logic [CNT_W-1:0]  cnt    [NUM_VC];
    logic [CNT_W-1:0]  cnt_next [NUM_VC];

    logic [NUM_VC-1:0] empty_q, full_q, on_off_q, on_off_next;
    logic              err_ovf_q, err_udf_q;

    logic              wr_vc_ok, rd_vc_ok;
    logic [VC_W-1:0]   wr_idx, rd_idx;
    logic              wr_ok, rd_ok;
    logic [NUM_VC-1:0] wr_sel, rd_sel;
    logic [NUM_VC*CNT_W-1:0] count_packed;

    // When NUM_VC fills the VC field, every encoding is a legal VC.
    generate
        if (NUM_VC == (1 << VC_W)) begin : g_full_range
            assign wr_vc_ok = 1'b1;
            assign rd_vc_ok = 1'b1;
        end else begin : g_part_range
            assign wr_vc_ok = (32'(bus.wr_vc) < NUM_VC);
            assign rd_vc_ok = (32'(bus.rd_vc) < NUM_VC);
        end
    endgenerate

    assign wr_idx = wr_vc_ok ? bus.wr_vc : '0;
    assign rd_idx = rd_vc_ok ? bus.rd_vc : '0;

    // A full VC still takes a write when the same VC pops in the same cycle.
    assign rd_ok = bus.rd_en && rd_vc_ok && (cnt[rd_idx] != '0);
    assign wr_ok = bus.wr_en && wr_vc_ok &&
                   ((cnt[wr_idx] != DEPTH_C) || (rd_ok && (rd_idx == wr_idx)));

    assign bus.rd_data  = mem[rd_idx][rd_ptr[rd_idx]];
    assign bus.rd_valid = rd_vc_ok && (cnt[rd_idx] != '0);

    always_comb begin
        wr_sel       = '0;
        rd_sel       = '0;
        on_off_next  = on_off_q;
        count_packed = '0;
        for (int i = 0; i < NUM_VC; i++) begin
            wr_sel[i]   = wr_ok && (wr_idx == VC_W'(i));
            rd_sel[i]   = rd_ok && (rd_idx == VC_W'(i));
            cnt_next[i] = cnt[i];
            if (wr_sel[i] && !rd_sel[i]) begin
                cnt_next[i] = cnt[i] + 1'b1;
            end else if (rd_sel[i] && !wr_sel[i]) begin
                cnt_next[i] = cnt[i] - 1'b1;
            end
            // Between the thresholds the credit signal keeps its last value.
            if (cnt_next[i] >= OFF_C) begin
                on_off_next[i] = 1'b0;
            end else if (cnt_next[i] <= ON_C) begin
                on_off_next[i] = 1'b1;
            end
            count_packed[i*CNT_W +: CNT_W] = cnt[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_VC; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                cnt[i]    <= '0;
            end
            empty_q   <= '1;
            full_q    <= '0;
            on_off_q  <= '1;
            err_ovf_q <= 1'b0;
            err_udf_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_VC; i++) begin
                if (wr_sel[i]) begin
                    wr_ptr[i] <= (wr_ptr[i] == PTR_LAST) ? '0 : wr_ptr[i] + 1'b1;
                end
                if (rd_sel[i]) begin
                    rd_ptr[i] <= (rd_ptr[i] == PTR_LAST) ? '0 : rd_ptr[i] + 1'b1;
                end
                cnt[i]     <= cnt_next[i];
                empty_q[i] <= (cnt_next[i] == '0);
                full_q[i]  <= (cnt_next[i] == DEPTH_C);
            end
            on_off_q  <= on_off_next;
            err_ovf_q <= bus.wr_en && !wr_ok;
            err_udf_q <= bus.rd_en && !rd_ok;
        end
    end

    // Flit storage carries no reset; validity is tracked by the counters.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_idx][wr_ptr[wr_idx]] <= bus.wr_data;
        end
    end

    assign bus.empty         = empty_q;
    assign bus.full          = full_q;
    assign bus.count         = count_packed;
    assign bus.on_off        = on_off_q;
    assign bus.err_overflow  = err_ovf_q;
    assign bus.err_underflow = err_udf_q;
endmodule

// File: tb/tb_vc_circular_buffer.sv
// Directed bench for vc_circular_buffer: a DEPTH=4 instance for the main
// scenarios and a DEPTH=5 instance for pointer wrap.
module tb_vc_circular_buffer;
  localparam int DATA_W = 8;
  localparam int NUM_VC = 2;
  localparam int CNT_W  = 3;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] exp_d;

  vc_circular_buffer_if #(.DATA_W(DATA_W), .DEPTH(4), .NUM_VC(NUM_VC)) a_if();
  vc_circular_buffer_if #(.DATA_W(DATA_W), .DEPTH(5), .NUM_VC(NUM_VC)) b_if();

  vc_circular_buffer #(.DATA_W(DATA_W), .DEPTH(4), .NUM_VC(NUM_VC), .ON_TH(1), .OFF_TH(3))
    dut_a (.clk(clk), .rst(rst), .bus(a_if.slave));
  vc_circular_buffer #(.DATA_W(DATA_W), .DEPTH(5), .NUM_VC(NUM_VC), .ON_TH(1), .OFF_TH(3))
    dut_b (.clk(clk), .rst(rst), .bus(b_if.slave));

  logic [CNT_W-1:0] a_cnt0, a_cnt1, b_cnt0, b_cnt1;
  assign a_cnt0 = a_if.count[CNT_W-1:0];
  assign a_cnt1 = a_if.count[2*CNT_W-1:CNT_W];
  assign b_cnt0 = b_if.count[CNT_W-1:0];
  assign b_cnt1 = b_if.count[2*CNT_W-1:CNT_W];

  // driver tasks: inputs applied 1 time unit after an edge, held over one edge
  task automatic drive_a(input logic we, input logic wvc, input logic [DATA_W-1:0] wd,
                         input logic re, input logic rvc);
    a_if.wr_en = we; a_if.wr_vc = wvc; a_if.wr_data = wd;
    a_if.rd_en = re; a_if.rd_vc = rvc;
    @(posedge clk); #1;
    a_if.wr_en = 1'b0; a_if.rd_en = 1'b0;
  endtask

  task automatic drive_b(input logic we, input logic [DATA_W-1:0] wd, input logic re);
    b_if.wr_en = we; b_if.wr_vc = 1'b1; b_if.wr_data = wd;
    b_if.rd_en = re; b_if.rd_vc = 1'b1;
    @(posedge clk); #1;
    b_if.wr_en = 1'b0; b_if.rd_en = 1'b0;
  endtask

  task automatic test_reset();
    a_if.wr_en = 0; a_if.wr_vc = 0; a_if.wr_data = '0; a_if.rd_en = 0; a_if.rd_vc = 0;
    b_if.wr_en = 0; b_if.wr_vc = 1; b_if.wr_data = '0; b_if.rd_en = 0; b_if.rd_vc = 1;
    rst = 1'b1;
    @(posedge clk); #1;
    n_tests++; if (a_if.count !== 6'd0) begin n_fail++; $display("FAIL reset_count got %h exp 0", a_if.count); end
    n_tests++; if (a_if.empty !== 2'b11) begin n_fail++; $display("FAIL reset_empty got %b exp 11", a_if.empty); end
    n_tests++; if (a_if.full !== 2'b00) begin n_fail++; $display("FAIL reset_full got %b exp 00", a_if.full); end
    n_tests++; if (a_if.on_off !== 2'b11) begin n_fail++; $display("FAIL reset_on_off got %b exp 11", a_if.on_off); end
    n_tests++; if ({a_if.err_overflow, a_if.err_underflow} !== 2'b00) begin n_fail++; $display("FAIL reset_err got %b exp 00", {a_if.err_overflow, a_if.err_underflow}); end
    n_tests++; if (a_if.rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid got %b exp 0", a_if.rd_valid); end
    n_tests++; if (b_if.count !== 6'd0) begin n_fail++; $display("FAIL reset_count_b got %h exp 0", b_if.count); end
    rst = 1'b0;
  endtask

  task automatic test_fill();
    logic [NUM_VC-1:0] on_exp;
    for (int k = 1; k <= 4; k++) begin
      exp_d = 8'hA0 + 8'(k);
      drive_a(1'b1, 1'b0, exp_d, 1'b0, 1'b0);
      exp_q.push_back(exp_d);
      on_exp = (k >= 3) ? 2'b10 : 2'b11;
      n_tests++; if (a_cnt0 !== 3'(k)) begin n_fail++; $display("FAIL fill_count0 k=%0d got %0d exp %0d", k, a_cnt0, k); end
      n_tests++; if (a_if.on_off !== on_exp) begin n_fail++; $display("FAIL fill_on_off k=%0d got %b exp %b", k, a_if.on_off, on_exp); end
      n_tests++; if (a_if.full[0] !== (k == 4)) begin n_fail++; $display("FAIL fill_full0 k=%0d got %b exp %b", k, a_if.full[0], (k == 4)); end
      n_tests++; if (a_if.empty !== 2'b10) begin n_fail++; $display("FAIL fill_empty k=%0d got %b exp 10", k, a_if.empty); end
      n_tests++; if (a_cnt1 !== 3'd0) begin n_fail++; $display("FAIL fill_count1 k=%0d got %0d exp 0", k, a_cnt1); end
    end
  endtask

  task automatic test_overflow();
    drive_a(1'b1, 1'b0, 8'hA5, 1'b0, 1'b0);
    n_tests++; if (a_if.err_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_pulse got %b exp 1", a_if.err_overflow); end
    n_tests++; if (a_if.err_underflow !== 1'b0) begin n_fail++; $display("FAIL ovf_no_udf got %b exp 0", a_if.err_underflow); end
    n_tests++; if (a_cnt0 !== 3'd4) begin n_fail++; $display("FAIL ovf_count0 got %0d exp 4", a_cnt0); end
    drive_a(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    n_tests++; if (a_if.err_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_one_cycle got %b exp 0", a_if.err_overflow); end
  endtask

  task automatic test_full_rw();
    a_if.rd_vc = 1'b0; #1;
    n_tests++; if (a_if.rd_data !== exp_q[0]) begin n_fail++; $display("FAIL full_rw_head got %h exp %h", a_if.rd_data, exp_q[0]); end
    drive_a(1'b1, 1'b0, 8'hB0, 1'b1, 1'b0);
    void'(exp_q.pop_front());
    exp_q.push_back(8'hB0);
    n_tests++; if (a_cnt0 !== 3'd4) begin n_fail++; $display("FAIL full_rw_count0 got %0d exp 4", a_cnt0); end
    n_tests++; if (a_if.full[0] !== 1'b1) begin n_fail++; $display("FAIL full_rw_full0 got %b exp 1", a_if.full[0]); end
    n_tests++; if ({a_if.err_overflow, a_if.err_underflow} !== 2'b00) begin n_fail++; $display("FAIL full_rw_err got %b exp 00", {a_if.err_overflow, a_if.err_underflow}); end
    n_tests++; if (a_if.rd_data !== exp_q[0]) begin n_fail++; $display("FAIL full_rw_next_head got %h exp %h", a_if.rd_data, exp_q[0]); end
  endtask

  task automatic test_drain();
    logic exp_on [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    for (int k = 0; k < 4; k++) begin
      a_if.rd_vc = 1'b0; #1;
      exp_d = exp_q.pop_front();
      n_tests++; if (a_if.rd_valid !== 1'b1) begin n_fail++; $display("FAIL drain_valid k=%0d got %b exp 1", k, a_if.rd_valid); end
      n_tests++; if (a_if.rd_data !== exp_d) begin n_fail++; $display("FAIL drain_data k=%0d got %h exp %h", k, a_if.rd_data, exp_d); end
      drive_a(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      n_tests++; if (a_cnt0 !== 3'(3 - k)) begin n_fail++; $display("FAIL drain_count0 k=%0d got %0d exp %0d", k, a_cnt0, 3 - k); end
      n_tests++; if (a_if.on_off[0] !== exp_on[k]) begin n_fail++; $display("FAIL drain_on_off k=%0d got %b exp %b", k, a_if.on_off[0], exp_on[k]); end
      n_tests++; if (a_if.empty[0] !== (k == 3)) begin n_fail++; $display("FAIL drain_empty0 k=%0d got %b exp %b", k, a_if.empty[0], (k == 3)); end
    end
    n_tests++; if (a_if.rd_valid !== 1'b0) begin n_fail++; $display("FAIL drain_valid_end got %b exp 0", a_if.rd_valid); end
    drive_a(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    n_tests++; if (a_if.err_underflow !== 1'b1) begin n_fail++; $display("FAIL udf_pulse got %b exp 1", a_if.err_underflow); end
    n_tests++; if (a_cnt0 !== 3'd0) begin n_fail++; $display("FAIL udf_count0 got %0d exp 0", a_cnt0); end
  endtask

  task automatic test_empty_rw();
    drive_a(1'b1, 1'b1, 8'hC1, 1'b1, 1'b1);
    n_tests++; if (a_if.err_underflow !== 1'b1) begin n_fail++; $display("FAIL empty_rw_udf got %b exp 1", a_if.err_underflow); end
    n_tests++; if (a_if.err_overflow !== 1'b0) begin n_fail++; $display("FAIL empty_rw_ovf got %b exp 0", a_if.err_overflow); end
    n_tests++; if (a_cnt1 !== 3'd1) begin n_fail++; $display("FAIL empty_rw_count1 got %0d exp 1", a_cnt1); end
    n_tests++; if (a_if.empty !== 2'b01) begin n_fail++; $display("FAIL empty_rw_empty got %b exp 01", a_if.empty); end
    a_if.rd_vc = 1'b1; #1;
    n_tests++; if (a_if.rd_valid !== 1'b1) begin n_fail++; $display("FAIL empty_rw_valid got %b exp 1", a_if.rd_valid); end
    n_tests++; if (a_if.rd_data !== 8'hC1) begin n_fail++; $display("FAIL empty_rw_data got %h exp c1", a_if.rd_data); end
  endtask

  task automatic test_diff_vc();
    drive_a(1'b1, 1'b0, 8'hD1, 1'b1, 1'b1);
    n_tests++; if (a_cnt0 !== 3'd1) begin n_fail++; $display("FAIL diff_count0 got %0d exp 1", a_cnt0); end
    n_tests++; if (a_cnt1 !== 3'd0) begin n_fail++; $display("FAIL diff_count1 got %0d exp 0", a_cnt1); end
    n_tests++; if ({a_if.err_overflow, a_if.err_underflow} !== 2'b00) begin n_fail++; $display("FAIL diff_err got %b exp 00", {a_if.err_overflow, a_if.err_underflow}); end
    n_tests++; if (a_if.empty !== 2'b10) begin n_fail++; $display("FAIL diff_empty got %b exp 10", a_if.empty); end
    a_if.rd_vc = 1'b0; #1;
    n_tests++; if (a_if.rd_data !== 8'hD1) begin n_fail++; $display("FAIL diff_data got %h exp d1", a_if.rd_data); end
  endtask

  task automatic test_wrap();
    exp_q.delete();
    for (int i = 0; i <= 10; i++) begin
      if (i > 0) begin
        exp_d = exp_q.pop_front();
        n_tests++; if (b_if.rd_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_valid i=%0d got %b exp 1", i, b_if.rd_valid); end
        n_tests++; if (b_if.rd_data !== exp_d) begin n_fail++; $display("FAIL wrap_data i=%0d got %h exp %h", i, b_if.rd_data, exp_d); end
      end
      if (i < 10) exp_q.push_back(8'h50 + 8'(i));
      drive_b(i < 10, 8'h50 + 8'(i), i > 0);
      n_tests++; if (b_cnt1 !== ((i < 10) ? 3'd1 : 3'd0)) begin n_fail++; $display("FAIL wrap_count1 i=%0d got %0d exp %0d", i, b_cnt1, (i < 10) ? 1 : 0); end
      n_tests++; if ({b_if.err_overflow, b_if.err_underflow} !== 2'b00) begin n_fail++; $display("FAIL wrap_err i=%0d got %b exp 00", i, {b_if.err_overflow, b_if.err_underflow}); end
    end
    n_tests++; if (b_cnt0 !== 3'd0) begin n_fail++; $display("FAIL wrap_count0 got %0d exp 0", b_cnt0); end
  endtask

  task automatic test_async_reset();
    drive_a(1'b1, 1'b0, 8'hE1, 1'b0, 1'b0);
    drive_a(1'b1, 1'b0, 8'hE2, 1'b0, 1'b0);
    n_tests++; if (a_cnt0 !== 3'd3) begin n_fail++; $display("FAIL arst_pre_count0 got %0d exp 3", a_cnt0); end
    n_tests++; if (a_if.on_off !== 2'b10) begin n_fail++; $display("FAIL arst_pre_on_off got %b exp 10", a_if.on_off); end
    #3 rst = 1'b1;
    #1;
    n_tests++; if (a_if.count !== 6'd0) begin n_fail++; $display("FAIL arst_count got %h exp 0", a_if.count); end
    n_tests++; if (a_if.empty !== 2'b11) begin n_fail++; $display("FAIL arst_empty got %b exp 11", a_if.empty); end
    n_tests++; if (a_if.on_off !== 2'b11) begin n_fail++; $display("FAIL arst_on_off got %b exp 11", a_if.on_off); end
    n_tests++; if (a_if.rd_valid !== 1'b0) begin n_fail++; $display("FAIL arst_rd_valid got %b exp 0", a_if.rd_valid); end
    @(posedge clk); #1;
    rst = 1'b0;
    drive_a(1'b1, 1'b0, 8'hF1, 1'b0, 1'b0);
    a_if.rd_vc = 1'b0; #1;
    n_tests++; if (a_cnt0 !== 3'd1) begin n_fail++; $display("FAIL arst_post_count0 got %0d exp 1", a_cnt0); end
    n_tests++; if (a_if.rd_data !== 8'hF1) begin n_fail++; $display("FAIL arst_post_data got %h exp f1", a_if.rd_data); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_full_rw();
    test_drain();
    test_empty_rw();
    test_diff_vc();
    test_wrap();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/vc_circular_buffer.md
# vc_circular_buffer

Parametrised multi-virtual-channel input buffer for the NoC router input port. It holds NUM_VC independent circular FIFOs of DEPTH flits each, all in one storage array. It exposes per-VC occupancy, full/empty and hysteretic on/off flow-control signals to the upstream router, plus overflow/underflow error pulses. It sits between the link receiver and the VC allocator / switch arbiter, which select the VC to read.

## Interface

- DATA_W, default 32: flit width in bits.
- DEPTH, default 8: entries per VC; any value ≥ 2 (not restricted to powers of two).
- NUM_VC, default 2: number of virtual channels; ≥ 1.
- ON_TH, default 1: on/off asserts when VC occupancy ≤ ON_TH.
- OFF_TH, default 6: on/off deasserts when VC occupancy ≥ OFF_TH; requires ON_TH < OFF_TH ≤ DEPTH.
- VC_W, derived: max(1, $clog2(NUM_VC)).
- CNT_W, derived: $clog2(DEPTH+1).

Ports:

- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  write request.
- wr_vc  in  VC_W  target VC of write.
- wr_data  in  DATA_W  flit to store.
- rd_en  in  1  read (pop) request.
- rd_vc  in  VC_W  VC to read.
- rd_data  out  DATA_W  head flit of rd_vc, combinational from storage.
- rd_valid  out  1  rd_vc is non-empty, combinational.
- empty  out  NUM_VC  per-VC empty, registered.
- full  out  NUM_VC  per-VC full, registered.
- count  out  NUM_VC*CNT_W  per-VC occupancy, registered; VC i at bits [i*CNT_W +: CNT_W].
- on_off  out  NUM_VC  per-VC credit-on signal to upstream, registered.
- err_overflow  out  1  one-cycle pulse for a write that was dropped.
- err_underflow  out  1  one-cycle pulse for a read that was rejected.

## Operation

- Per VC: wr_ptr, rd_ptr (each $clog2(DEPTH) bits, min 1) and count. Pointers advance by 1 and wrap to 0 after DEPTH-1 (explicit compare, not modulo-2^n).
- Write accepted iff wr_en and (count[wr_vc] < DEPTH, or an accepted read on the same VC in the same cycle). Accepted write stores wr_data at wr_ptr[wr_vc] and advances that pointer.
- Read accepted iff rd_en and count[rd_vc] > 0 (pre-cycle value). Accepted read advances rd_ptr[rd_vc]. rd_data is valid only while rd_valid=1; otherwise its value is don't-care.
- Same VC, read+write: full VC → both accepted, count unchanged. Empty VC → read rejected (underflow), write accepted, count +1. No write-through bypass.
- Different VCs: independent; both may be accepted.
- Count update: +1 on write only, −1 on read only, unchanged on both or neither. empty = (count_next == 0). full = (count_next == DEPTH).
- on_off per VC, evaluated on count_next: if ≥ OFF_TH → 0; else if ≤ ON_TH → 1; else holds previous value (hysteresis).
- Rejected write: storage and pointers untouched; err_overflow=1 next cycle. Rejected read: err_underflow=1 next cycle. Both may pulse together.
- wr_vc/rd_vc ≥ NUM_VC: request is ignored and flagged as overflow (write) or underflow (read), respectively.

## Timing

- Reset values: all pointers 0, count 0, empty all 1, full all 0, on_off all 1, err_* 0. Storage is not reset. rd_valid=0 as a result of reset.
- Reset asserted mid-operation clears all state immediately (asynchronous). The first accepted operation is on the first rising edge after rst deasserts.
- Write-to-read latency: 1 cycle. A flit written at edge N appears on rd_data (if it is the head) and empty/count update after edge N.
- Read: rd_data/rd_valid are combinational on rd_vc in the same cycle. The pop takes effect at the edge.
- Throughput: one write and one read per cycle, sustained.

## Test plan

(DATA_W=8, DEPTH=4, NUM_VC=2, ON_TH=1, OFF_TH=3 unless noted)

- Reset then write 0xA1,0xA2,0xA3,0xA4 to VC0 → count0 goes 1,2,3,4. full[0]=1 after 4th write. on_off[0]=0 after 3rd write. VC1 unchanged.
- VC0 full, 5th write 0xA5 → err_overflow pulses 1 cycle; count0 stays 4; subsequent reads return A1..A4 in order, then empty[0]=1.
- Read VC0 from count 4 down → on_off[0] stays 0 at count 2, returns to 1 at count 1 (hysteresis).
- Wrap: 10 write/read pairs on VC1 at DEPTH=5 → data order preserved across pointer wrap at 4→0, count never exceeds 1.
- Simultaneous read+write on full VC0 → count stays 4, head advances. On empty VC1 → err_underflow=1, count1=1, rd_data later shows the written flit.
- Assert rst after 3 writes to VC0 → count=0, empty=all 1, on_off=all 1 immediately, without waiting for a clock edge.
